// File: rtl/encoder8x3_pending.sv
// Sequential 8-to-3 priority encoder: latches request lines into a pending
// register and offers the highest-priority eligible index over a valid/ack handshake.
//
// state | meaning
// IDLE  | no offer outstanding; loads code when any pending & mask bit is set
// OFFER | valid high, code frozen until ack
module encoder8x3_pending #(
    parameter bit STICKY     = 1'b1,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       multi
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q;
    logic       valid_q;

    logic [7:0] elig;
    logic [7:0] clr;
    logic [2:0] sel_idx;
    logic [3:0] elig_cnt;

    assign elig = pending_q & mask;

    always_comb begin
        sel_idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (elig[i]) sel_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (elig[i]) sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        elig_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            elig_cnt = elig_cnt + {3'd0, elig[i]};
        end
    end

    assign multi = (elig_cnt >= 4'd2);

    // A request arriving alongside its own clear is a new event and survives.
    always_comb begin
        clr = 8'd0;
        if (valid_q && ack) clr = 8'd1 << code_q;
        if (STICKY) pending_d = (pending_q & ~clr) | req;
        else        pending_d = req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (elig != 8'd0) begin
                        code_q  <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_encoder8x3_pending.sv
// Directed bench for encoder8x3_pending: default, low-first and non-sticky
// instances share one stimulus set.
module tb_encoder8x3_pending;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;

    logic [2:0] code_h, code_l, code_n;
    logic       valid_h, valid_l, valid_n;
    logic [7:0] pend_h, pend_l, pend_n;
    logic       multi_h, multi_l, multi_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    encoder8x3_pending #(.STICKY(1'b1), .HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
        .code(code_h), .valid(valid_h), .pending(pend_h), .multi(multi_h)
    );

    encoder8x3_pending #(.STICKY(1'b1), .HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
        .code(code_l), .valid(valid_l), .pending(pend_l), .multi(multi_l)
    );

    encoder8x3_pending #(.STICKY(1'b0), .HIGH_FIRST(1'b1)) u_ns (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
        .code(code_n), .valid(valid_n), .pending(pend_n), .multi(multi_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; mask = 8'hFF; ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; mask = 8'hFF; ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({valid_h, pend_h} !== 9'h000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got valid=%b pending=%h want valid=0 pending=00", i, valid_h, pend_h);
            end
        end
        rst = 1'b0; req = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({valid_h, pend_h, valid_n, pend_n} !== 18'h0) begin
            bad++;
            $display("FAIL reset_after got valid=%b pending=%h ns_valid=%b ns_pending=%h want all 0",
                     valid_h, pend_h, valid_n, pend_n);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h20;
        tick();
        req = 8'h00;
        total++;
        if ({valid_h, pend_h} !== {1'b0, 8'h20}) begin
            bad++;
            $display("FAIL single_capture got valid=%b pending=%h want valid=0 pending=20", valid_h, pend_h);
        end
        tick();
        total++;
        if ({valid_h, code_h} !== {1'b1, 3'd5}) begin
            bad++;
            $display("FAIL single_offer got valid=%b code=%0d want valid=1 code=5", valid_h, code_h);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if ({valid_h, pend_h} !== 9'h000) begin
            bad++;
            $display("FAIL single_ack got valid=%b pending=%h want valid=0 pending=00", valid_h, pend_h);
        end
        tick();
        total++;
        if (valid_h !== 1'b0) begin
            bad++;
            $display("FAIL single_no_reoffer got valid=%b want 0", valid_h);
        end
    endtask

    task automatic test_priority();
        do_reset();
        req = 8'h81;
        tick();
        req = 8'h00;
        total++;
        if (multi_h !== 1'b1) begin
            bad++;
            $display("FAIL prio_multi_pre got %b want 1", multi_h);
        end
        tick();
        total++;
        if ({valid_h, code_h, valid_l, code_l, multi_h} !== {1'b1, 3'd7, 1'b1, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL prio_first got hi=%b/%0d lo=%b/%0d multi=%b want hi=1/7 lo=1/0 multi=1",
                     valid_h, code_h, valid_l, code_l, multi_h);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if ({valid_h, pend_h, multi_h, valid_l, pend_l} !== {1'b0, 8'h01, 1'b0, 1'b0, 8'h80}) begin
            bad++;
            $display("FAIL prio_bubble got hi=%b/%h multi=%b lo=%b/%h want hi=0/01 multi=0 lo=0/80",
                     valid_h, pend_h, multi_h, valid_l, pend_l);
        end
        tick();
        total++;
        if ({valid_h, code_h, valid_l, code_l} !== {1'b1, 3'd0, 1'b1, 3'd7}) begin
            bad++;
            $display("FAIL prio_second got hi=%b/%0d lo=%b/%0d want hi=1/0 lo=1/7",
                     valid_h, code_h, valid_l, code_l);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if ({valid_h, pend_h, valid_l, pend_l} !== 18'h0) begin
            bad++;
            $display("FAIL prio_drained got hi=%b/%h lo=%b/%h want all 0", valid_h, pend_h, valid_l, pend_l);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        total++;
        if ({valid_h, code_h} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL hold_start got valid=%b code=%0d want valid=1 code=3", valid_h, code_h);
        end
        req = 8'h80; mask = 8'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({valid_h, code_h} !== {1'b1, 3'd3}) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got valid=%b code=%0d want valid=1 code=3", i, valid_h, code_h);
            end
        end
        ack = 1'b1; req = 8'h00;
        tick();
        ack = 1'b0;
        total++;
        if ({valid_h, pend_h} !== {1'b0, 8'h80}) begin
            bad++;
            $display("FAIL hold_ack got valid=%b pending=%h want valid=0 pending=80", valid_h, pend_h);
        end
        tick();
        total++;
        if ({valid_h, code_h} !== {1'b1, 3'd7}) begin
            bad++;
            $display("FAIL hold_next got valid=%b code=%0d want valid=1 code=7", valid_h, code_h);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0; mask = 8'hFF;
    endtask

    task automatic test_mask_rereq();
        do_reset();
        mask = 8'hFE; req = 8'h01;
        tick();
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({valid_h, pend_h} !== {1'b0, 8'h01}) begin
                bad++;
                $display("FAIL mask_block cyc=%0d got valid=%b pending=%h want valid=0 pending=01", i, valid_h, pend_h);
            end
        end
        mask = 8'hFF;
        tick();
        total++;
        if ({valid_h, code_h} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL rereq_offer got valid=%b code=%0d want valid=1 code=0", valid_h, code_h);
        end
        ack = 1'b1; req = 8'h01;
        tick();
        ack = 1'b0; req = 8'h00;
        total++;
        if ({valid_h, pend_h} !== {1'b0, 8'h01}) begin
            bad++;
            $display("FAIL rereq_kept got valid=%b pending=%h want valid=0 pending=01", valid_h, pend_h);
        end
        tick();
        total++;
        if ({valid_h, code_h} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL rereq_reoffer got valid=%b code=%0d want valid=1 code=0", valid_h, code_h);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_nonsticky();
        do_reset();
        req = 8'h04;
        tick();
        req = 8'h00;
        total++;
        if ({valid_n, pend_n} !== {1'b0, 8'h04}) begin
            bad++;
            $display("FAIL ns_capture got valid=%b pending=%h want valid=0 pending=04", valid_n, pend_n);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({valid_n, code_n, pend_n} !== {1'b1, 3'd2, 8'h00}) begin
                bad++;
                $display("FAIL ns_persist cyc=%0d got valid=%b code=%0d pending=%h want valid=1 code=2 pending=00",
                         i, valid_n, code_n, pend_n);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (valid_n !== 1'b0) begin
            bad++;
            $display("FAIL ns_ack got valid=%b want 0", valid_n);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h10;
        tick();
        tick();
        total++;
        if ({valid_h, code_h, valid_n, code_n} !== {1'b1, 3'd4, 1'b1, 3'd4}) begin
            bad++;
            $display("FAIL midrst_offer got hi=%b/%0d ns=%b/%0d want 1/4 both", valid_h, code_h, valid_n, code_n);
        end
        rst = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; ack = 1'b0; req = 8'h00;
        total++;
        if ({valid_h, pend_h, code_h, valid_n, pend_n} !== 21'h0) begin
            bad++;
            $display("FAIL midrst_clear got hi valid=%b pending=%h code=%0d ns valid=%b pending=%h want all 0",
                     valid_h, pend_h, code_h, valid_n, pend_n);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'hFF;
        tick();
        req = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            tick();
            total++;
            if ({valid_h, code_h, valid_l, code_l} !== {1'b1, 3'(i), 1'b1, 3'(7 - i)}) begin
                bad++;
                $display("FAIL drain_order step=%0d got hi=%b/%0d lo=%b/%0d want hi=1/%0d lo=1/%0d",
                         7 - i, valid_h, code_h, valid_l, code_l, i, 7 - i);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        tick();
        tick();
        total++;
        if ({valid_h, pend_h, code_h, valid_l, pend_l, code_l} !== {1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7}) begin
            bad++;
            $display("FAIL drain_empty got hi=%b/%h/%0d lo=%b/%h/%0d want hi=0/00/0 lo=0/00/7",
                     valid_h, pend_h, code_h, valid_l, pend_l, code_l);
        end
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; mask = 8'hFF; ack = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_hold();
        test_mask_rereq();
        test_nonsticky();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
